// File: rtl/pipe_hazard_seq_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_hazard_seq_pkg;
  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEMWAIT,
    ST_DRAIN,
    ST_HALT
  } state_t;
endpackage

// File: rtl/pipe_hazard_seq_if.sv
// Sequencer bus: decode/EX/MEM status in, stall/flush/freeze control out.
interface pipe_hazard_seq_if #(
  parameter int CNT_W = 16
);
  import pipe_hazard_seq_pkg::*;

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_pause;
  logic [REG_W-1:0] ex_rd;
  logic             ex_memtoreg;
  logic             ex_writesreg;
  logic             ex_brtaken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             resume;
  logic             stall_pc;
  logic             stall_ifid;
  logic             flush_ifid;
  logic             flush_idex;
  logic             freeze;
  logic             halted;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_pause,
           ex_rd, ex_memtoreg, ex_writesreg, ex_brtaken,
           dmem_req, dmem_ready, resume,
    input  stall_pc, stall_ifid, flush_ifid, flush_idex,
           freeze, halted, timeout_err, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_pause,
           ex_rd, ex_memtoreg, ex_writesreg, ex_brtaken,
           dmem_req, dmem_ready, resume,
    output stall_pc, stall_ifid, flush_ifid, flush_idex,
           freeze, halted, timeout_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_seq_hazard_detect.sv
// Load-use detector: a load in EX whose destination is read by the instruction in ID.
module pipe_hazard_seq_hazard_detect
  import pipe_hazard_seq_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memtoreg,
  input  logic             ex_writesreg,
  output logic             load_use
);
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign load_use = ex_memtoreg && ex_writesreg && (ex_rd != '0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/pipe_hazard_seq.sv
// Pipeline sequencer: load-use bubbles, branch squash, dmem wait freeze, pause drain/halt/resume.
module pipe_hazard_seq
  import pipe_hazard_seq_pkg::*;
#(
  parameter int DRAIN_CYC   = 3,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input logic              clk,
  input logic              rst_n,
  pipe_hazard_seq_if.slave bus
);
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state, state_nx, ret_st, ret_nx, eff;
  logic [DW-1:0]    dcnt, dcnt_nx;
  logic [WW-1:0]    wcnt, wcnt_nx;
  logic             rflush, rflush_nx;
  logic             terr, terr_nx;
  logic [CNT_W-1:0] scnt;
  logic             load_use, memwait, frozen;
  logic             stall_pc_c, stall_ifid_c, flush_ifid_c, flush_idex_c, freeze_c, halted_c;

  pipe_hazard_seq_hazard_detect u_hazard (
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_use_rs1  (bus.id_use_rs1),
    .id_use_rs2  (bus.id_use_rs2),
    .ex_rd       (bus.ex_rd),
    .ex_memtoreg (bus.ex_memtoreg),
    .ex_writesreg(bus.ex_writesreg),
    .load_use    (load_use)
  );

  always_comb begin
    memwait      = bus.dmem_req && !bus.dmem_ready;
    frozen       = (state == ST_MEMWAIT) ? !bus.dmem_ready : ((state != ST_HALT) && memwait);
    // on the release cycle of a wait, behave as the state the wait interrupted
    eff          = (state == ST_MEMWAIT) ? ret_st : state;
    state_nx     = state;
    ret_nx       = ret_st;
    dcnt_nx      = dcnt;
    wcnt_nx      = '0;
    rflush_nx    = rflush;
    terr_nx      = terr;
    stall_pc_c   = 1'b0;
    stall_ifid_c = 1'b0;
    flush_ifid_c = 1'b0;
    flush_idex_c = 1'b0;
    freeze_c     = 1'b0;
    halted_c     = 1'b0;
    if (state == ST_HALT) begin
      freeze_c = 1'b1;
      halted_c = 1'b1;
      if (bus.resume) begin
        state_nx  = ST_RUN;
        rflush_nx = 1'b1;
      end
    end else if (frozen) begin
      freeze_c = 1'b1;
      if (state != ST_MEMWAIT) ret_nx = state;
      if (int'(wcnt) + 1 >= MEM_TIMEOUT) begin
        terr_nx  = 1'b1;
        state_nx = ST_HALT;
      end else begin
        state_nx = ST_MEMWAIT;
        wcnt_nx  = wcnt + WW'(1);
      end
    end else if (eff == ST_DRAIN) begin
      stall_pc_c   = 1'b1;
      stall_ifid_c = 1'b1;
      flush_idex_c = 1'b1;
      if (int'(dcnt) == DRAIN_CYC - 1) begin
        state_nx = ST_HALT;
        dcnt_nx  = '0;
      end else begin
        state_nx = ST_DRAIN;
        dcnt_nx  = dcnt + DW'(1);
      end
    end else begin
      state_nx = ST_RUN;
      // first unfrozen cycle after resume squashes the pause still sitting in IF/ID
      if (rflush) begin
        flush_ifid_c = 1'b1;
        rflush_nx    = 1'b0;
      end else if (bus.ex_brtaken) begin
        flush_ifid_c = 1'b1;
        flush_idex_c = 1'b1;
      end else if (load_use) begin
        stall_pc_c   = 1'b1;
        stall_ifid_c = 1'b1;
        flush_idex_c = 1'b1;
      end else if (bus.id_pause) begin
        state_nx = ST_DRAIN;
        dcnt_nx  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_RUN;
      ret_st <= ST_RUN;
      dcnt   <= '0;
      wcnt   <= '0;
      rflush <= 1'b0;
      terr   <= 1'b0;
      scnt   <= '0;
    end else begin
      state  <= state_nx;
      ret_st <= ret_nx;
      dcnt   <= dcnt_nx;
      wcnt   <= wcnt_nx;
      rflush <= rflush_nx;
      terr   <= terr_nx;
      if ((stall_pc_c || freeze_c) && !halted_c) scnt <= sat_inc(scnt);
    end
  end

  // outputs are forced low while reset is held, independent of the live inputs
  assign bus.stall_pc    = rst_n && stall_pc_c;
  assign bus.stall_ifid  = rst_n && stall_ifid_c;
  assign bus.flush_ifid  = rst_n && flush_ifid_c;
  assign bus.flush_idex  = rst_n && flush_idex_c;
  assign bus.freeze      = rst_n && freeze_c;
  assign bus.halted      = rst_n && halted_c;
  assign bus.timeout_err = terr;
  assign bus.stall_cnt   = scnt;
endmodule

// File: tb/tb_pipe_hazard_seq.sv
// Directed bench for pipe_hazard_seq with an expected-output scoreboard.
module tb_pipe_hazard_seq;
  logic clk;
  logic rst_n;

  pipe_hazard_seq_if #(.CNT_W(16)) bus ();
  pipe_hazard_seq_if #(.CNT_W(2))  bus2 ();

  pipe_hazard_seq #(.DRAIN_CYC(3), .MEM_TIMEOUT(255), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  pipe_hazard_seq #(.DRAIN_CYC(3), .MEM_TIMEOUT(3), .CNT_W(2)) dut_to (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  // bit order: stall_pc stall_ifid flush_ifid flush_idex freeze halted timeout_err
  localparam logic [6:0] O_NONE = 7'b000_0000;
  localparam logic [6:0] O_LU   = 7'b110_1000;
  localparam logic [6:0] O_BR   = 7'b001_1000;
  localparam logic [6:0] O_FRZ  = 7'b000_0100;
  localparam logic [6:0] O_DRN  = 7'b110_1000;
  localparam logic [6:0] O_HLT  = 7'b000_0110;
  localparam logic [6:0] O_RFL  = 7'b001_0000;
  localparam logic [6:0] O_TERR = 7'b000_0001;

  logic [6:0]  exp_q[$];
  int unsigned ecnt[2];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [6:0]  o1, o2;

  assign o1 = {bus.stall_pc, bus.stall_ifid, bus.flush_ifid, bus.flush_idex,
               bus.freeze, bus.halted, bus.timeout_err};
  assign o2 = {bus2.stall_pc, bus2.stall_ifid, bus2.flush_ifid, bus2.flush_idex,
               bus2.freeze, bus2.halted, bus2.timeout_err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clr();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.id_pause = 0; bus.ex_rd = '0; bus.ex_memtoreg = 0; bus.ex_writesreg = 0;
    bus.ex_brtaken = 0; bus.dmem_req = 0; bus.dmem_ready = 0; bus.resume = 0;
    bus2.id_rs1 = '0; bus2.id_rs2 = '0; bus2.id_use_rs1 = 0; bus2.id_use_rs2 = 0;
    bus2.id_pause = 0; bus2.ex_rd = '0; bus2.ex_memtoreg = 0; bus2.ex_writesreg = 0;
    bus2.ex_brtaken = 0; bus2.dmem_req = 0; bus2.dmem_ready = 0; bus2.resume = 0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    bus.ex_rd = rd; bus.ex_memtoreg = 1; bus.ex_writesreg = 1;
  endtask

  // pop the expected vector for this cycle and compare outputs and stall counter
  task automatic check_out(input bit sel, input string tag);
    logic [6:0]  e;
    logic [6:0]  obs;
    logic [15:0] cobs;
    logic [15:0] cexp;
    int unsigned cmax;
    obs  = sel ? o2 : o1;
    cobs = sel ? 16'(bus2.stall_cnt) : bus.stall_cnt;
    cexp = 16'(ecnt[sel]);
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %b expected <entry>", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: outputs observed %b expected %b", tag, obs, e);
    end
    n_chk++;
    assert (cobs === cexp) else begin
      n_fail++;
      $error("FAIL %s_cnt: stall_cnt observed %0d expected %0d", tag, cobs, cexp);
    end
    cmax = sel ? 32'd3 : 32'd65535;
    if ((e[6] || e[2]) && !e[1] && ecnt[sel] < cmax) ecnt[sel]++;
  endtask

  task automatic cyc(input bit sel, input logic [6:0] e, input string tag);
    exp_q.push_back(e);
    #2;
    check_out(sel, tag);
    @(negedge clk);
  endtask

  // async reset asserted mid-cycle with the current inputs still applied
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    ecnt[0] = 0;
    ecnt[1] = 0;
    #1;
    exp_q.push_back(O_NONE);
    check_out(0, {tag, "_d0"});
    exp_q.push_back(O_NONE);
    check_out(1, {tag, "_d1"});
    @(negedge clk);
    clr();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    clr();
    ecnt[0] = 0;
    ecnt[1] = 0;
    #1 rst_n = 1'b0;
    #1;
    exp_q.push_back(O_NONE); check_out(0, "reset_d0");
    exp_q.push_back(O_NONE); check_out(1, "reset_d1");
    @(negedge clk);
    rst_n = 1'b1;

    cyc(0, O_NONE, "idle");
    // lw x5 in EX, add x6,x5,x1 in ID
    set_load(5); bus.id_rs1 = 5; bus.id_use_rs1 = 1; bus.id_rs2 = 1; bus.id_use_rs2 = 1;
    cyc(0, O_LU, "lu_rs1");
    clr(); cyc(0, O_NONE, "lu_after");
    set_load(0); bus.id_rs1 = 0; bus.id_use_rs1 = 1;
    cyc(0, O_NONE, "lu_x0");
    clr(); set_load(7); bus.id_rs1 = 3; bus.id_use_rs1 = 1; bus.id_rs2 = 7; bus.id_use_rs2 = 1;
    cyc(0, O_LU, "lu_rs2");
    bus.id_use_rs2 = 0;
    cyc(0, O_NONE, "lu_unused");
    clr(); bus.ex_rd = 7; bus.ex_memtoreg = 1; bus.id_rs1 = 7; bus.id_use_rs1 = 1;
    cyc(0, O_NONE, "lu_nowrite");
    bus.ex_memtoreg = 0; bus.ex_writesreg = 1;
    cyc(0, O_NONE, "lu_noload");
    clr(); set_load(5); bus.id_rs1 = 5; bus.id_use_rs1 = 1; bus.ex_brtaken = 1;
    cyc(0, O_BR, "br_and_lu");
    clr(); bus.ex_brtaken = 1;
    cyc(0, O_BR, "br_only");
    clr(); cyc(0, O_NONE, "br_after");

    // four-cycle dmem wait with branch and load-use masked while frozen
    bus.dmem_req = 1; bus.dmem_ready = 0;
    cyc(0, O_FRZ, "mw_1");
    bus.ex_brtaken = 1;
    cyc(0, O_FRZ, "mw_2_br");
    bus.ex_brtaken = 0; set_load(5); bus.id_rs1 = 5; bus.id_use_rs1 = 1;
    cyc(0, O_FRZ, "mw_3_lu");
    clr(); bus.dmem_req = 1;
    cyc(0, O_FRZ, "mw_4");
    bus.dmem_ready = 1; bus.ex_brtaken = 1;
    cyc(0, O_BR, "mw_release_br");
    clr(); cyc(0, O_NONE, "mw_after");

    // pause: drain, halt, resume
    bus.id_pause = 1;
    cyc(0, O_NONE, "pause_accept");
    bus.id_pause = 0;
    cyc(0, O_DRN, "drain_1");
    cyc(0, O_DRN, "drain_2");
    cyc(0, O_DRN, "drain_3");
    cyc(0, O_HLT, "halt_1");
    bus.resume = 1;
    cyc(0, O_HLT, "halt_resume");
    bus.resume = 0; bus.id_pause = 1;
    cyc(0, O_RFL, "resume_flush");
    bus.id_pause = 0;
    cyc(0, O_NONE, "resume_after");
    bus.resume = 1;
    cyc(0, O_NONE, "resume_in_run");
    bus.resume = 0;

    // pause with a two-cycle memwait inside the drain
    bus.id_pause = 1;
    cyc(0, O_NONE, "pmw_accept");
    bus.id_pause = 0;
    cyc(0, O_DRN, "pmw_drain_1");
    bus.dmem_req = 1; bus.dmem_ready = 0;
    cyc(0, O_FRZ, "pmw_frz_1");
    cyc(0, O_FRZ, "pmw_frz_2");
    bus.dmem_ready = 1;
    cyc(0, O_DRN, "pmw_release");
    clr();
    cyc(0, O_DRN, "pmw_drain_3");
    cyc(0, O_HLT, "pmw_halt");
    bus.resume = 1;
    cyc(0, O_HLT, "pmw_resume");
    bus.resume = 0;
    cyc(0, O_RFL, "pmw_flush");
    cyc(0, O_NONE, "pmw_after");

    // pause under a taken branch is dropped
    bus.id_pause = 1; bus.ex_brtaken = 1;
    cyc(0, O_BR, "pause_br");
    clr();
    cyc(0, O_NONE, "pause_dropped_1");
    cyc(0, O_NONE, "pause_dropped_2");

    // reset during drain
    bus.id_pause = 1;
    cyc(0, O_NONE, "rd_accept");
    bus.id_pause = 0;
    cyc(0, O_DRN, "rd_drain_1");
    bus.dmem_req = 1; bus.dmem_ready = 0;
    exp_q.push_back(O_FRZ);
    #2 check_out(0, "rd_frz");
    mid_reset("rst_drain");
    cyc(0, O_NONE, "rd_post_1");
    cyc(0, O_NONE, "rd_post_2");

    // reset during memwait
    bus.dmem_req = 1; bus.dmem_ready = 0;
    cyc(0, O_FRZ, "rm_frz_1");
    cyc(0, O_FRZ, "rm_frz_2");
    mid_reset("rst_memwait");
    cyc(0, O_NONE, "rm_post");

    // timeout on the short-timeout instance; its 2-bit counter also saturates
    bus2.dmem_req = 1; bus2.dmem_ready = 0;
    cyc(1, O_FRZ, "to_frz_1");
    cyc(1, O_FRZ, "to_frz_2");
    cyc(1, O_FRZ, "to_frz_3");
    cyc(1, O_HLT | O_TERR, "to_halt");
    bus2.resume = 1;
    cyc(1, O_HLT | O_TERR, "to_resume");
    bus2.resume = 0; bus2.dmem_req = 0;
    cyc(1, O_RFL | O_TERR, "to_flush_sticky");
    bus2.dmem_req = 1;
    cyc(1, O_FRZ | O_TERR, "sat_frz_1");
    cyc(1, O_FRZ | O_TERR, "sat_frz_2");
    bus2.dmem_ready = 1;
    cyc(1, O_TERR, "sat_release");
    clr();
    cyc(1, O_TERR, "sat_hold");
    mid_reset("rst_terr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
